// File: rtl/ctrl_seq.sv
// ctrl_seq -- small instruction sequencer for a nibble-oriented datapath.
//
// Accepts one instruction at a time through a valid/ready handshake, latches
// it into an instruction register (IR) and walks it through a fixed sequence
// of phases: DECODE, then either EXEC+WB (ALU ops), MEM (+WB for loads), HALT,
// or straight back to IDLE for unrecognised opcodes. Every decoded output is
// taken from the IR so the upstream source may change instr freely once the
// handshake has completed.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   instr        instruction word, opcode in the upper OPCODE_W bits
//   instr_valid  instr is being presented
//   instr_ready  sequencer is idle and will take instr this cycle
//   mem_req      memory request, held for every cycle spent in MEM
//   mem_we       write qualifier for mem_req (store-byte only)
//   mem_ack      memory access complete (ignored outside MEM)
//   addr_offset  latched operand, used as memory address offset
//   nibble_out   latched operand
//   reg_sel      latched operand, register select
//   reg16_src    upper half of latched operand
//   reg16_dst    lower half of latched operand
//   alu_op       latched opcode with its MSB stripped
//   alu_shamt    latched operand, ALU shift amount
//   alu_en       one-cycle ALU strobe
//   reg_we       one-cycle register write-back strobe
//   halted       sequencer is parked in HALT until reset
//   err          sticky memory-timeout flag, cleared only by reset

module ctrl_seq #(
  parameter int          OPCODE_W    = 4,
  parameter int          OPERAND_W   = 4,   // must be even and >= 2
  parameter int unsigned OPC_LDB     = 'hC,
  parameter int unsigned OPC_STB     = 'hD,
  parameter int unsigned OPC_HLT     = 'hF,
  parameter int          MEM_TIMEOUT = 15   // 1..255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [OPCODE_W+OPERAND_W-1:0] instr,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic                          mem_req,
  output logic                          mem_we,
  input  logic                          mem_ack,
  output logic [OPERAND_W-1:0]          addr_offset,
  output logic [OPERAND_W-1:0]          nibble_out,
  output logic [OPERAND_W-1:0]          reg_sel,
  output logic [OPERAND_W/2-1:0]        reg16_src,
  output logic [OPERAND_W/2-1:0]        reg16_dst,
  output logic [OPCODE_W-2:0]           alu_op,
  output logic [OPERAND_W-1:0]          alu_shamt,
  output logic                          alu_en,
  output logic                          reg_we,
  output logic                          halted,
  output logic                          err
);

  localparam int INSTR_W = OPCODE_W + OPERAND_W;
  localparam int HALF_W  = OPERAND_W / 2;

  // Opcode constants trimmed to the actual opcode width so comparisons
  // against the IR are width-exact for any parameterisation.
  localparam logic [OPCODE_W-1:0] LDB_CODE = OPCODE_W'(OPC_LDB);
  localparam logic [OPCODE_W-1:0] STB_CODE = OPCODE_W'(OPC_STB);
  localparam logic [OPCODE_W-1:0] HLT_CODE = OPCODE_W'(OPC_HLT);

  // The wait counter sees values 0..MEM_TIMEOUT-1 while still in MEM; the
  // cycle that starts with MEM_TIMEOUT-1 and gets no ack is the last one.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [7:0]           wait_q, wait_d;
  logic                 err_q, err_d;
  logic                 alu_en_q, alu_en_d;
  logic                 reg_we_q, reg_we_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;

  logic [OPCODE_W-1:0]  ir_opcode;
  logic [OPERAND_W-1:0] ir_operand;
  logic                 is_ldb;
  logic                 is_stb;
  logic                 is_hlt;

  assign ir_opcode  = ir_q[INSTR_W-1 -: OPCODE_W];
  assign ir_operand = ir_q[OPERAND_W-1:0];

  assign is_ldb = (ir_opcode == LDB_CODE);
  assign is_stb = (ir_opcode == STB_CODE);
  assign is_hlt = (ir_opcode == HLT_CODE);

  // Next-state and datapath-register logic. The IR only loads on a handshake
  // in IDLE, so everything downstream sees a stable instruction for the whole
  // sequence. MEM exits on ack (honoured even on the very first MEM cycle) or
  // on timeout, which raises the sticky error flag and abandons the access.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!ir_opcode[OPCODE_W-1]) begin
          state_d = ST_EXEC;
        end else if (is_ldb || is_stb) begin
          state_d = ST_MEM;
          wait_d  = 8'd0;
        end else if (is_hlt) begin
          state_d = ST_HALT;
        end else begin
          // Unrecognised opcode with MSB set: silently dropped.
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        state_d = ST_WB;
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      ST_MEM: begin
        if (mem_ack) begin
          state_d = is_stb ? ST_IDLE : ST_WB;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          wait_d  = wait_q + 8'd1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are computed from the upcoming state and registered, so each one
  // is a clean flop output that is high exactly while the matching state is
  // current (EXEC -> alu_en, WB -> reg_we, MEM -> mem_req/mem_we).
  always_comb begin
    alu_en_d  = (state_d == ST_EXEC);
    reg_we_d  = (state_d == ST_WB);
    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = (state_d == ST_MEM) && is_stb;
  end

  // State and strobe registers. The asynchronous reset drops mem_req at once,
  // even in the middle of an outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      wait_q    <= 8'd0;
      err_q     <= 1'b0;
      alu_en_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      alu_en_q  <= alu_en_d;
      reg_we_q  <= reg_we_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;

  assign alu_en  = alu_en_q;
  assign reg_we  = reg_we_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;

  assign addr_offset = ir_operand;
  assign nibble_out  = ir_operand;
  assign reg_sel     = ir_operand;
  assign alu_shamt   = ir_operand;
  assign reg16_src   = ir_operand[OPERAND_W-1 -: HALF_W];
  assign reg16_dst   = ir_operand[HALF_W-1:0];
  assign alu_op      = ir_opcode[OPCODE_W-2:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- self-checking bench for ctrl_seq.
//
// Two instances: the default parameterisation (dut) and a wide one with
// OPCODE_W=5, OPERAND_W=6 (dut_w). Directed instructions are issued to dut;
// for each one the expected per-cycle strobe pattern is pushed into a
// scoreboard queue, and a monitor pops one entry for every cycle in which
// dut raises any strobe. Status signals are checked directly by the stimulus.

module tb_ctrl_seq;

  logic        clk;
  logic        rst_n;

  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [3:0]  addr_offset;
  logic [3:0]  nibble_out;
  logic [3:0]  reg_sel;
  logic [1:0]  reg16_src;
  logic [1:0]  reg16_dst;
  logic [2:0]  alu_op;
  logic [3:0]  alu_shamt;
  logic        alu_en;
  logic        reg_we;
  logic        halted;
  logic        err;

  logic [10:0] w_instr;
  logic        w_instr_valid;
  logic        w_instr_ready;
  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_mem_ack;
  logic [5:0]  w_addr_offset;
  logic [5:0]  w_nibble_out;
  logic [5:0]  w_reg_sel;
  logic [2:0]  w_reg16_src;
  logic [2:0]  w_reg16_dst;
  logic [3:0]  w_alu_op;
  logic [5:0]  w_alu_shamt;
  logic        w_alu_en;
  logic        w_reg_we;
  logic        w_halted;
  logic        w_err;

  int checks;
  int errors;

  // Scoreboard entry: {alu_en, reg_we, mem_req, mem_we, alu_op[2:0], operand[3:0]}
  logic [10:0] exp_q[$];

  ctrl_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .addr_offset (addr_offset),
    .nibble_out  (nibble_out),
    .reg_sel     (reg_sel),
    .reg16_src   (reg16_src),
    .reg16_dst   (reg16_dst),
    .alu_op      (alu_op),
    .alu_shamt   (alu_shamt),
    .alu_en      (alu_en),
    .reg_we      (reg_we),
    .halted      (halted),
    .err         (err)
  );

  ctrl_seq #(
    .OPCODE_W  (5),
    .OPERAND_W (6)
  ) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (w_instr),
    .instr_valid (w_instr_valid),
    .instr_ready (w_instr_ready),
    .mem_req     (w_mem_req),
    .mem_we      (w_mem_we),
    .mem_ack     (w_mem_ack),
    .addr_offset (w_addr_offset),
    .nibble_out  (w_nibble_out),
    .reg_sel     (w_reg_sel),
    .reg16_src   (w_reg16_src),
    .reg16_dst   (w_reg16_dst),
    .alu_op      (w_alu_op),
    .alu_shamt   (w_alu_shamt),
    .alu_en      (w_alu_en),
    .reg_we      (w_reg_we),
    .halted      (w_halted),
    .err         (w_err)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [10:0] mk(input logic a, input logic r, input logic m,
                                     input logic w, input logic [2:0] op,
                                     input logic [3:0] opd);
    return {a, r, m, w, op, opd};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Fails (and moves on) if instr_ready does not come back within the budget.
  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (!instr_ready && n < budget) begin
      cyc();
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_ready timed out after %0d cycles", budget);
    end
  endtask

  // Presents one instruction for exactly one accepted cycle; returns #1 after
  // the accepting edge, i.e. with the sequencer in DECODE.
  task automatic applyStimulus(input logic [7:0] v);
    waitReady(50);
    instr       = v;
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
  endtask

  // Waits for mem_req, lets n cycles pass without ack, then acks for one cycle.
  task automatic memAck(input int n);
    int k;
    k = 0;
    while (!mem_req && k < 10) begin
      cyc();
      k++;
    end
    if (!mem_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_mem_req timed out got 0 want 1");
    end
    repeat (n) cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
  endtask

  // Monitor: every cycle in which dut shows any strobe must match the next
  // scoreboard entry; a strobe with nothing expected is itself a failure.
  always @(negedge clk) begin
    logic [10:0] obs;
    logic [10:0] expv;
    if (rst_n && (alu_en || reg_we || mem_req || mem_we)) begin
      obs = {alu_en, reg_we, mem_req, mem_we, alu_op,
             (mem_req ? addr_offset : alu_shamt)};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected got %0h want none", obs);
      end else begin
        expv = exp_q.pop_front();
        checkOutput("sb_strobe", 32'(obs), 32'(expv));
      end
    end
  end

  // Directed test sequence.
  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    instr         = 8'h00;
    instr_valid   = 1'b0;
    mem_ack       = 1'b0;
    w_instr       = 11'h000;
    w_instr_valid = 1'b0;
    w_mem_ack     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_alu_en", 32'(alu_en), 0);
    checkOutput("rst_reg_we", 32'(reg_we), 0);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_halted", 32'(halted), 0);
    rst_n = 1'b1;
    cyc();
    checkOutput("rst_ready", 32'(instr_ready), 1);

    $display("[TB] wide instance ALU op 11'h0AB");
    w_instr       = 11'h0AB;
    w_instr_valid = 1'b1;
    cyc();
    w_instr_valid = 1'b0;
    checkOutput("w_alu_en_decode", 32'(w_alu_en), 0);
    cyc();
    checkOutput("w_alu_en_exec", 32'(w_alu_en), 1);
    checkOutput("w_reg16_src", 32'(w_reg16_src), 32'h5);
    checkOutput("w_reg16_dst", 32'(w_reg16_dst), 32'h3);
    checkOutput("w_alu_op", 32'(w_alu_op), 32'h2);
    cyc();
    checkOutput("w_alu_en_wb", 32'(w_alu_en), 0);
    checkOutput("w_reg_we_wb", 32'(w_reg_we), 1);

    $display("[TB] ALU 8'h25");
    exp_q.push_back(mk(1, 0, 0, 0, 3'h2, 4'h5));
    exp_q.push_back(mk(0, 1, 0, 0, 3'h2, 4'h5));
    applyStimulus(8'h25);
    checkOutput("alu_ready_decode", 32'(instr_ready), 0);
    cyc();
    cyc();
    checkOutput("alu_ready_wb", 32'(instr_ready), 0);
    cyc();
    checkOutput("alu_ready_back", 32'(instr_ready), 1);

    $display("[TB] STB 8'hD6 ack after 3 waits");
    repeat (4) exp_q.push_back(mk(0, 0, 1, 1, 3'h5, 4'h6));
    applyStimulus(8'hD6);
    memAck(3);
    checkOutput("stb_ready", 32'(instr_ready), 1);
    checkOutput("stb_mem_req_off", 32'(mem_req), 0);
    checkOutput("stb_err", 32'(err), 0);

    $display("[TB] STB 8'hDA immediate ack");
    exp_q.push_back(mk(0, 0, 1, 1, 3'h5, 4'hA));
    applyStimulus(8'hDA);
    memAck(0);
    checkOutput("stb_fast_ready", 32'(instr_ready), 1);

    $display("[TB] LDB 8'hC7 immediate ack");
    exp_q.push_back(mk(0, 0, 1, 0, 3'h4, 4'h7));
    exp_q.push_back(mk(0, 1, 0, 0, 3'h4, 4'h7));
    applyStimulus(8'hC7);
    memAck(0);
    checkOutput("ldb_ready_wb", 32'(instr_ready), 0);
    cyc();
    checkOutput("ldb_ready_back", 32'(instr_ready), 1);

    $display("[TB] no-op 8'hA0 and stray ack in IDLE");
    applyStimulus(8'hA0);
    cyc();
    checkOutput("nop_ready", 32'(instr_ready), 1);
    mem_ack = 1'b1;
    cyc();
    cyc();
    mem_ack = 1'b0;
    checkOutput("idle_ack_ready", 32'(instr_ready), 1);

    $display("[TB] LDB 8'hC9 timeout then ALU 8'h11");
    repeat (15) exp_q.push_back(mk(0, 0, 1, 0, 3'h4, 4'h9));
    applyStimulus(8'hC9);
    waitReady(40);
    checkOutput("to_mem_req_off", 32'(mem_req), 0);
    checkOutput("to_err", 32'(err), 1);
    exp_q.push_back(mk(1, 0, 0, 0, 3'h1, 4'h1));
    exp_q.push_back(mk(0, 1, 0, 0, 3'h1, 4'h1));
    applyStimulus(8'h11);
    waitReady(10);
    checkOutput("to_err_sticky", 32'(err), 1);

    $display("[TB] reset during MEM wait of 8'hC3");
    repeat (2) exp_q.push_back(mk(0, 0, 1, 0, 3'h4, 4'h3));
    applyStimulus(8'hC3);
    cyc();
    checkOutput("mrst_mem_req_on", 32'(mem_req), 1);
    cyc();
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_mem_req", 32'(mem_req), 0);
    checkOutput("mrst_mem_we", 32'(mem_we), 0);
    checkOutput("mrst_err", 32'(err), 0);
    checkOutput("mrst_shamt", 32'(alu_shamt), 0);
    checkOutput("mrst_ready", 32'(instr_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    checkOutput("mrst_ready_after", 32'(instr_ready), 1);

    $display("[TB] HALT 8'hF0");
    applyStimulus(8'hF0);
    cyc();
    instr       = 8'h25;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_halted", 32'(halted), 1);
      checkOutput("halt_ready", 32'(instr_ready), 0);
      cyc();
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    checkOutput("halt_exit_halted", 32'(halted), 0);
    checkOutput("halt_exit_ready", 32'(instr_ready), 1);

    repeat (3) cyc();
    checkOutput("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter OPCODE_W, default 4, opcode field width (instr upper bits).
REQ-002 Parameter OPERAND_W, default 4, operand field width (instr lower bits); SHALL be even and >=2.
REQ-003 Parameter OPC_LDB, default 4'hC, load-byte opcode value.
REQ-004 Parameter OPC_STB, default 4'hD, store-byte opcode value.
REQ-005 Parameter OPC_HLT, default 4'hF, halt opcode value.
REQ-006 Parameter MEM_TIMEOUT, default 15, max wait cycles for mem_ack (1..255).
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 instr  input  OPCODE_W+OPERAND_W  instruction; opcode = upper OPCODE_W bits.
REQ-010 instr_valid  input  1  instr presented.
REQ-011 instr_ready  output  1  controller accepts instr this cycle.
REQ-012 mem_req  output  1  memory access request.
REQ-013 mem_we  output  1  write qualifier for mem_req.
REQ-014 mem_ack  input  1  memory access complete.
REQ-015 addr_offset, nibble_out, reg_sel  output  OPERAND_W each  latched operand.
REQ-016 reg16_src, reg16_dst  output  OPERAND_W/2 each  upper/lower half of latched operand.
REQ-017 alu_op  output  OPCODE_W-1  latched opcode without MSB.
REQ-018 alu_shamt  output  OPERAND_W  latched operand.
REQ-019 alu_en  output  1  single-cycle ALU strobe.
REQ-020 reg_we  output  1  single-cycle register write-back strobe.
REQ-021 halted  output  1  controller in HALT.
REQ-022 err  output  1  sticky memory-timeout flag.

Function
REQ-023 On instr_valid && instr_ready, instr SHALL be captured into internal IR; all decoded outputs SHALL derive from IR, never from live instr.
REQ-024 States SHALL be IDLE, DECODE, EXEC, MEM, WB, HALT; instr_ready=1 only in IDLE.
REQ-025 IDLE: on handshake -> DECODE, else stay.
REQ-026 DECODE (1 cycle): IR opcode MSB=0 -> EXEC; opcode==OPC_LDB or OPC_STB -> MEM; opcode==OPC_HLT -> HALT; any other -> IDLE (no-op, no strobes).
REQ-027 EXEC: alu_en=1 for exactly that one cycle -> WB.
REQ-028 WB: reg_we=1 for exactly that one cycle -> IDLE.
REQ-029 MEM: mem_req=1 every cycle in MEM; mem_we=1 only when opcode==OPC_STB.
REQ-030 MEM with mem_ack=1: LDB -> WB; STB -> IDLE; mem_ack on the first MEM cycle SHALL be honoured.
REQ-031 Wait counter SHALL clear on MEM entry and increment each MEM cycle without mem_ack; when it reaches MEM_TIMEOUT without ack, err SHALL set, mem_req SHALL drop next cycle, state -> IDLE, no reg_we.
REQ-032 mem_ack outside MEM SHALL be ignored.
REQ-033 err SHALL stay set until reset; it SHALL NOT block further instructions.
REQ-034 HALT: halted=1, instr_ready=0, all strobes 0; only reset exits.
REQ-035 Minimum latency from accept to IDLE: ALU 4 cycles (DECODE, EXEC, WB, IDLE), STB with immediate ack 3, LDB with immediate ack 4.
REQ-036 alu_en, reg_we, mem_req SHALL be registered (glitch-free) outputs.

Reset
REQ-037 rst_n=0 SHALL force, asynchronously: state IDLE, IR=0, counter 0, err=0, halted=0, alu_en=reg_we=mem_req=mem_we=0; instr_ready=1 from the first clock after deassertion.
REQ-038 Reset asserted mid-MEM SHALL drop mem_req immediately without waiting for mem_ack.

Verification
REQ-039 Reset, instr=8'h25 valid one cycle -> alu_op=3'h2, alu_shamt=4'h5, alu_en high exactly one cycle, reg_we high the next cycle, instr_ready high again 4 cycles after accept.
REQ-040 instr=8'hD6, mem_ack held 0 for 3 cycles then 1 -> mem_req=mem_we=1 for 4 cycles, addr_offset=4'h6, no reg_we, return to IDLE.
REQ-041 instr=8'hC9, mem_ack never -> mem_req high for 15 cycles, err=1, IDLE; next instr=8'h11 executes normally with err still 1.
REQ-042 instr=8'hF0 -> halted=1, instr_ready=0 for 20 cycles despite instr_valid; rst_n pulse -> halted=0, instr_ready=1.
REQ-043 rst_n asserted during MEM wait of 8'hC3 -> mem_req=0 asynchronously, all outputs at reset values.
REQ-044 Instance with OPCODE_W=5, OPERAND_W=6, instr=11'h0AB valid -> reg16_src=3'h5, reg16_dst=3'h3, alu_op=4'h2, alu_en one cycle.
